// File: rtl/crossfade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crossfade_ramp_ctrl
// Purpose  : Ramps the crossfader level one LSB at a time toward a
//            commanded target. The rate is set by how many audio sample
//            ticks make up one step. A ramp can be frozen at its current
//            level with abort_i.
// Ports    : clk_i / rst_n_i      - clock, async active-low reset
//            sample_tick_i        - one-cycle audio sample strobe
//            cmd_valid_i/ready_o  - command handshake (ready only in IDLE)
//            cmd_target_i         - target level (0 = data_1, 255 = data_2)
//            cmd_period_i         - sample ticks per level step (0 acts as 1)
//            abort_i              - freeze the ramp, end it with done_o
//            level_o              - registered level toward the crossfader
//            busy_o               - ramp in progress
//            done_o               - one-cycle pulse when a ramp ends
// Revision : 1.0 - initial release
// ============================================================================
module crossfade_ramp_ctrl #(
    parameter logic [7:0] INIT_LEVEL = 8'd0,
    parameter int         PERIOD_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                sample_tick_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [7:0]          cmd_target_i,
    input  logic [PERIOD_W-1:0] cmd_period_i,
    input  logic                abort_i,
    output logic [7:0]          level_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [PERIOD_W-1:0] c_period_one = PERIOD_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [7:0]          level_q,    level_d;
    logic [7:0]          target_q,   target_d;
    logic [PERIOD_W-1:0] period_q,   period_d;
    logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic                done_q,     done_d;

    logic [PERIOD_W-1:0] w_tick_cnt_inc;
    logic                w_step_due;
    logic [7:0]          w_level_step;

    // The counter always stays below the latched period (which is at least
    // one), so the increment never wraps within PERIOD_W bits.
    assign w_tick_cnt_inc = tick_cnt_q + c_period_one;
    assign w_step_due     = sample_tick_i && (w_tick_cnt_inc == period_q);

    // Only used while level_q != target_q, so neither direction can wrap.
    assign w_level_step = (level_q < target_q) ? (level_q + 8'd1)
                                               : (level_q - 8'd1);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        target_d   = target_q;
        period_d   = period_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    target_d   = cmd_target_i;
                    period_d   = (cmd_period_i == '0) ? c_period_one : cmd_period_i;
                    tick_cnt_d = '0;
                    if (cmd_target_i == level_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end

            ST_RAMP: begin
                if (abort_i) begin
                    // Abort wins over any step due in this cycle.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (level_q == target_q) begin
                    // Defensive: cannot be reached through the command path.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (w_step_due) begin
                    tick_cnt_d = '0;
                    level_d    = w_level_step;
                    // Leave RAMP on the same edge that lands on the target.
                    if (w_level_step == target_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (sample_tick_i) begin
                    tick_cnt_d = w_tick_cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            level_q    <= INIT_LEVEL;
            target_q   <= INIT_LEVEL;
            period_q   <= c_period_one;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            target_q   <= target_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
        end
    end

    assign level_o     = level_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q == ST_RAMP);
    assign cmd_ready_o = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crossfade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossfade_ramp_ctrl
// Purpose  : Self-checking bench for crossfade_ramp_ctrl. The stimulus
//            process pushes the expected level steps and done pulses into a
//            queue; a monitor pops and compares each time level_o moves or
//            done_o pulses. Control outputs are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossfade_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_period;
    logic       abort;
    logic [7:0] level;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    crossfade_ramp_ctrl #(
        .INIT_LEVEL (8'd0),
        .PERIOD_W   (8)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .sample_tick_i (sample_tick),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_target_i  (cmd_target),
        .cmd_period_i  (cmd_period),
        .abort_i       (abort),
        .level_o       (level),
        .busy_o        (busy),
        .done_o        (done)
    );

    typedef struct {
        bit         is_done;
        logic [7:0] level;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev_level = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor: scoreboard side ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (level !== prev_level) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_level_change: got %0d expected %0d", level, prev_level);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("level_step", {23'd0, e.is_done, level}, {23'd0, 1'b0, e.level});
                end
                prev_level = level;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at level %0d expected no done", level);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("done_pulse", {23'd0, e.is_done, level}, {23'd0, 1'b1, e.level});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_ramp(input int from_l, input int to_l);
        ev_t e;
        int  v;
        v = from_l;
        while (v != to_l) begin
            v = (v < to_l) ? v + 1 : v - 1;
            e.is_done = 1'b0;
            e.level   = 8'(v);
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.level   = 8'(to_l);
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send_cmd(input logic [7:0] tgt, input logic [7:0] per);
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_period = per;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    // Counts busy samples until done_o is seen or the budget runs out.
    task automatic wait_done(input string name, input int budget, output int busy_cycles);
        bit ok;
        ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
        end
        check({name, "_done_within_budget"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        rst_n       = 1'b0;
        sample_tick = 1'b1;
        cmd_valid   = 1'b0;
        cmd_target  = 8'd0;
        cmd_period  = 8'd0;
        abort       = 1'b0;

        // Reset values
        idle_cycles(3);
        check("reset_level", level, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", cmd_ready, 1);

        // 0 -> 4, period 2, command accepted on the first edge after release
        prev_level = level;
        mon_en     = 1'b1;
        push_ramp(0, 4);
        rst_n = 1'b1;
        send_cmd(8'd4, 8'd2);
        check("accept_first_edge_busy", busy, 1);
        check("ramp_ready_low", cmd_ready, 0);
        wait_done("ramp_0_4", 50, bc);
        check("ramp_0_4_busy_ticks", bc, 8);
        check("ramp_0_4_level", level, 4);
        idle_cycles(1);
        check("after_ramp_ready", cmd_ready, 1);
        check("after_ramp_busy", busy, 0);

        // Ticks in IDLE do nothing
        idle_cycles(5);
        check("idle_ticks_level", level, 4);

        // Climb to 200, then 200 -> 198 with period 0 (acts as 1)
        push_ramp(4, 200);
        send_cmd(8'd200, 8'd1);
        wait_done("ramp_4_200", 400, bc);
        check("ramp_4_200_busy_ticks", bc, 196);
        push_ramp(200, 198);
        send_cmd(8'd198, 8'd0);
        wait_done("ramp_200_198", 20, bc);
        check("period0_busy_ticks", bc, 2);
        check("period0_level", level, 198);

        // Down to 37, then a command to the current level
        push_ramp(198, 37);
        send_cmd(8'd37, 8'd1);
        wait_done("ramp_198_37", 400, bc);
        push_ramp(37, 37);
        send_cmd(8'd37, 8'd5);
        check("same_target_done_next", done, 1);
        check("same_target_busy", busy, 0);
        wait_done("same_target", 5, bc);
        check("same_target_busy_ticks", bc, 0);

        // 37 -> 0, then 0 -> 255 aborted on a step cycle at level 100
        push_ramp(37, 0);
        send_cmd(8'd0, 8'd1);
        wait_done("ramp_37_0", 100, bc);
        idle_cycles(1);
        begin
            ev_t e;
            for (int v = 1; v <= 100; v++) begin
                e.is_done = 1'b0;
                e.level   = 8'(v);
                exp_q.push_back(e);
            end
            e.is_done = 1'b1;
            e.level   = 8'd100;
            exp_q.push_back(e);
        end
        send_cmd(8'd255, 8'd1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (level == 8'd100) begin
                    hit = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("abort_reach_100", {31'd0, hit}, 32'd1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_level_held", level, 100);
        check("abort_ready", cmd_ready, 1);
        idle_cycles(2);
        check("abort_level_stays", level, 100);

        // abort in IDLE is ignored
        abort = 1'b1;
        idle_cycles(2);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Command held valid during a ramp: 100 -> 50, then 10 accepted on return to IDLE
        push_ramp(100, 50);
        push_ramp(50, 10);
        cmd_valid  = 1'b1;
        cmd_target = 8'd50;
        cmd_period = 8'd1;
        @(posedge clk); #1;
        cmd_target = 8'd10;
        wait_done("held_ramp_100_50", 200, bc);
        check("held_first_leg_ticks", bc, 50);
        check("held_ready_on_return", cmd_ready, 1);
        check("held_level_50", level, 50);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("held_reaccept_busy", busy, 1);
        wait_done("held_ramp_50_10", 200, bc);
        check("held_second_leg_ticks", bc, 40);
        idle_cycles(1);

        // Reset mid-ramp without a clock edge
        push_ramp(10, 60);
        send_cmd(8'd60, 8'd3);
        idle_cycles(10);
        check("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_level", level, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_ready", cmd_ready, 1);
        idle_cycles(2);
        check("reset_no_done", done, 0);
        prev_level = level;
        mon_en     = 1'b1;
        rst_n      = 1'b1;
        idle_cycles(4);
        check("post_reset_level", level, 0);

        idle_cycles(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
